// File: rtl/morra_pkg.sv
// rtl/morra_pkg.sv - shared types and constants for the rock-paper-scissors move acquisition stage
package morra_pkg;

  typedef logic [1:0] mossa_t;

  localparam mossa_t NESSUNA = 2'b00;
  localparam mossa_t SASSO   = 2'b01;
  localparam mossa_t CARTA   = 2'b10;
  localparam mossa_t FORBICE = 2'b11;

  typedef logic [1:0] esito_t;

  localparam esito_t IN_CORSO = 2'b00;
  localparam esito_t VINCE_A  = 2'b01;
  localparam esito_t VINCE_B  = 2'b10;
  localparam esito_t PAREGGIO = 2'b11;

  typedef enum logic [2:0] {
    FERMO,
    AVVIO,
    RACCOLTA,
    EMETTI,
    PAUSA
  } stato_t;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int larghezza(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/morra_slot_mossa.sv
// rtl/morra_slot_mossa.sv - per-player move holding register with valid/ready handshake
module morra_slot_mossa
  import morra_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  mossa_t mossa_i,
  input  logic   valido_i,
  input  logic   abilita_i,
  input  logic   svuota_i,
  output logic   pronto_o,
  output logic   pieno_o,
  output logic   cattura_o,
  output logic   invalida_o,
  output mossa_t mossa_prossima_o
);

  mossa_t mossa_q, mossa_d;
  logic   pieno_q, pieno_d;
  logic   pronto_q, pronto_d;
  logic   trasferimento;

  assign trasferimento    = valido_i && pronto_q;
  assign cattura_o        = trasferimento && (mossa_i != NESSUNA);
  assign invalida_o       = trasferimento && (mossa_i == NESSUNA);
  assign mossa_prossima_o = cattura_o ? mossa_i : mossa_q;

  // Clearing wins over a same-cycle capture (new match, timeout, leaving collection).
  always_comb begin
    pieno_d = pieno_q;
    mossa_d = mossa_q;
    if (svuota_i) begin
      pieno_d = 1'b0;
      mossa_d = NESSUNA;
    end else if (cattura_o) begin
      pieno_d = 1'b1;
      mossa_d = mossa_i;
    end
    pronto_d = abilita_i && !pieno_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mossa_q  <= NESSUNA;
      pieno_q  <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      mossa_q  <= mossa_d;
      pieno_q  <= pieno_d;
      pronto_q <= pronto_d;
    end
  end

  assign pronto_o = pronto_q;
  assign pieno_o  = pieno_q;

endmodule

// File: rtl/morra_acquisizione_mosse.sv
// rtl/morra_acquisizione_mosse.sv - collects both players' moves and feeds the round/match FSM
module morra_acquisizione_mosse
  import morra_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int HOLDOFF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mossa_a,
  input  logic       valido_a,
  output logic       pronto_a,
  input  logic [1:0] mossa_b,
  input  logic       valido_b,
  output logic       pronto_b,
  input  logic       avvia,
  input  logic [3:0] cfg_manche,
  input  logic [1:0] partita,
  output logic [1:0] primo,
  output logic [1:0] secondo,
  output logic       inizia,
  output logic       scaduto,
  output logic       errore,
  output logic       bloccato
);

  localparam int TW = larghezza(TIMEOUT);
  localparam int HW = larghezza(HOLDOFF);

  stato_t        stato_q, stato_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [HW-1:0] pausa_q, pausa_d;
  mossa_t        primo_q, primo_d;
  mossa_t        secondo_q, secondo_d;
  logic          inizia_q, inizia_d;
  logic          scaduto_q, scaduto_d;
  logic          errore_q, errore_d;
  logic          bloccato_q, bloccato_d;

  logic          abilita, svuota, scade;
  logic          pieno_a, cattura_a, invalida_a;
  logic          pieno_b, cattura_b, invalida_b;
  mossa_t        prossima_a, prossima_b;

  // Slots only hold moves while collecting; any exit or a timeout empties them.
  assign abilita = (stato_d == RACCOLTA);
  assign svuota  = (stato_d != RACCOLTA) || scade;

  morra_slot_mossa u_slot_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .mossa_i          (mossa_a),
    .valido_i         (valido_a),
    .abilita_i        (abilita),
    .svuota_i         (svuota),
    .pronto_o         (pronto_a),
    .pieno_o          (pieno_a),
    .cattura_o        (cattura_a),
    .invalida_o       (invalida_a),
    .mossa_prossima_o (prossima_a)
  );

  morra_slot_mossa u_slot_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .mossa_i          (mossa_b),
    .valido_i         (valido_b),
    .abilita_i        (abilita),
    .svuota_i         (svuota),
    .pronto_o         (pronto_b),
    .pieno_o          (pieno_b),
    .cattura_o        (cattura_b),
    .invalida_o       (invalida_b),
    .mossa_prossima_o (prossima_b)
  );

  always_comb begin
    stato_d = stato_q;
    tmr_d   = '0;
    pausa_d = '0;
    scade   = 1'b0;
    if (avvia) begin
      stato_d = AVVIO;
    end else begin
      case (stato_q)
        FERMO:  stato_d = FERMO;
        AVVIO:  stato_d = PAUSA;
        EMETTI: stato_d = PAUSA;
        PAUSA: begin
          if (pausa_q == HW'(HOLDOFF - 1)) begin
            stato_d = (partita == IN_CORSO) ? RACCOLTA : FERMO;
          end else begin
            pausa_d = pausa_q + 1'b1;
          end
        end
        RACCOLTA: begin
          // An opponent capture on the expiry cycle beats the timeout.
          if (partita != IN_CORSO) begin
            stato_d = FERMO;
          end else if ((pieno_a || cattura_a) && (pieno_b || cattura_b)) begin
            stato_d = EMETTI;
          end else if (pieno_a ^ pieno_b) begin
            if (tmr_q == TW'(TIMEOUT - 1)) begin
              scade = 1'b1;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end
        end
        default: stato_d = FERMO;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with stato_q.
  always_comb begin
    primo_d    = NESSUNA;
    secondo_d  = NESSUNA;
    inizia_d   = (stato_d == AVVIO);
    bloccato_d = (stato_d == FERMO);
    scaduto_d  = scade;
    errore_d   = invalida_a || invalida_b;
    if (stato_d == AVVIO) begin
      primo_d   = cfg_manche[3:2];
      secondo_d = cfg_manche[1:0];
    end else if (stato_d == EMETTI) begin
      primo_d   = prossima_a;
      secondo_d = prossima_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stato_q    <= FERMO;
      tmr_q      <= '0;
      pausa_q    <= '0;
      primo_q    <= NESSUNA;
      secondo_q  <= NESSUNA;
      inizia_q   <= 1'b0;
      scaduto_q  <= 1'b0;
      errore_q   <= 1'b0;
      bloccato_q <= 1'b1;
    end else begin
      stato_q    <= stato_d;
      tmr_q      <= tmr_d;
      pausa_q    <= pausa_d;
      primo_q    <= primo_d;
      secondo_q  <= secondo_d;
      inizia_q   <= inizia_d;
      scaduto_q  <= scaduto_d;
      errore_q   <= errore_d;
      bloccato_q <= bloccato_d;
    end
  end

  assign primo    = primo_q;
  assign secondo  = secondo_q;
  assign inizia   = inizia_q;
  assign scaduto  = scaduto_q;
  assign errore   = errore_q;
  assign bloccato = bloccato_q;

endmodule

// File: tb/tb_morra_acquisizione_mosse.sv
// tb/tb_morra_acquisizione_mosse.sv - table-driven bench for morra_acquisizione_mosse
module tb_morra_acquisizione_mosse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mossa_a = 2'b00;
  logic       valido_a = 1'b0;
  logic       pronto_a;
  logic [1:0] mossa_b = 2'b00;
  logic       valido_b = 1'b0;
  logic       pronto_b;
  logic       avvia = 1'b0;
  logic [3:0] cfg_manche = 4'b0000;
  logic [1:0] partita = 2'b00;
  logic [1:0] primo;
  logic [1:0] secondo;
  logic       inizia;
  logic       scaduto;
  logic       errore;
  logic       bloccato;

  int tests = 0;
  int failed = 0;

  morra_acquisizione_mosse #(.TIMEOUT(16), .HOLDOFF(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mossa_a    (mossa_a),
    .valido_a   (valido_a),
    .pronto_a   (pronto_a),
    .mossa_b    (mossa_b),
    .valido_b   (valido_b),
    .pronto_b   (pronto_b),
    .avvia      (avvia),
    .cfg_manche (cfg_manche),
    .partita    (partita),
    .primo      (primo),
    .secondo    (secondo),
    .inizia     (inizia),
    .scaduto    (scaduto),
    .errore     (errore),
    .bloccato   (bloccato)
  );

  always #5 clk = ~clk;

  // Output word: {primo, secondo, inizia, pronto_a, pronto_b, scaduto, errore, bloccato}
  logic [9:0] outs;
  assign outs = {primo, secondo, inizia, pronto_a, pronto_b, scaduto, errore, bloccato};

  localparam logic [9:0] O_FERMO = {4'b0000, 6'b000001};
  localparam logic [9:0] O_NULLO = {4'b0000, 6'b000000};
  localparam logic [9:0] O_RACC  = {4'b0000, 6'b011000};
  localparam logic [9:0] O_SOLOB = {4'b0000, 6'b001000};

  typedef struct {
    logic       avvia;
    logic [3:0] cfg;
    logic       va;
    logic [1:0] ma;
    logic       vb;
    logic [1:0] mb;
    logic [1:0] par;
    logic [9:0] exp_o;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic av, input logic [3:0] cfg, input logic va,
                             input logic [1:0] ma, input logic vb, input logic [1:0] mb,
                             input logic [1:0] par, input logic [9:0] e);
    vec_t r;
    r.avvia = av; r.cfg = cfg; r.va = va; r.ma = ma;
    r.vb = vb; r.mb = mb; r.par = par; r.exp_o = e;
    return r;
  endfunction

  task automatic chk(input string nome, input logic [9:0] act, input logic [9:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s: got %b expected %b (primo secondo inizia pa pb scad err blocc)",
               nome, act, exp_v);
    end
  endtask

  task automatic step(input vec_t t, input string nome);
    avvia = t.avvia; cfg_manche = t.cfg;
    valido_a = t.va; mossa_a = t.ma;
    valido_b = t.vb; mossa_b = t.mb;
    partita = t.par;
    @(posedge clk);
    #1;
    chk(nome, outs, t.exp_o);
  endtask

  task automatic idle(input logic [9:0] e, input string nome);
    step(v(0, 4'h0, 0, 2'b00, 0, 2'b00, 2'b00, e), nome);
  endtask

  task automatic avvio(input logic [3:0] cfg, input string nome);
    step(v(1, cfg, 0, 2'b00, 0, 2'b00, 2'b00, {cfg, 6'b100000}), {nome, "_avvio"});
    idle(O_NULLO, {nome, "_pausa0"});
    idle(O_NULLO, {nome, "_pausa1"});
    idle(O_RACC,  {nome, "_raccolta"});
  endtask

  initial begin
    // start/config, pause, collect
    vecs.push_back(v(1, 4'b0110, 0, 2'b00, 0, 2'b00, 2'b00, {4'b0110, 6'b100000}));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_RACC));
    // A rock, B scissors three cycles later
    vecs.push_back(v(0, 4'b0000, 1, 2'b01, 0, 2'b00, 2'b00, O_SOLOB));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_SOLOB));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_SOLOB));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 1, 2'b11, 2'b00, {4'b0111, 6'b000000}));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_RACC));
    // invalid move, then second valid while full, then B equal move
    vecs.push_back(v(0, 4'b0000, 1, 2'b00, 0, 2'b00, 2'b00, {4'b0000, 6'b011010}));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_RACC));
    vecs.push_back(v(0, 4'b0000, 1, 2'b10, 0, 2'b00, 2'b00, O_SOLOB));
    vecs.push_back(v(0, 4'b0000, 1, 2'b01, 0, 2'b00, 2'b00, O_SOLOB));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 1, 2'b10, 2'b00, {4'b1010, 6'b000000}));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_RACC));
    // same-edge pair, then match decided during pause
    vecs.push_back(v(0, 4'b0000, 1, 2'b11, 1, 2'b01, 2'b00, {4'b1101, 6'b000000}));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b01, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b01, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b01, O_FERMO));
    vecs.push_back(v(0, 4'b0000, 1, 2'b01, 1, 2'b10, 2'b00, O_FERMO));
    // restart; match decided during collection drops the slot
    vecs.push_back(v(1, 4'b1111, 0, 2'b00, 0, 2'b00, 2'b00, {4'b1111, 6'b100000}));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_RACC));
    vecs.push_back(v(0, 4'b0000, 1, 2'b01, 0, 2'b00, 2'b00, O_SOLOB));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b10, O_FERMO));
    // restart; avvia overrides a same-cycle capture that would complete the pair
    vecs.push_back(v(1, 4'b0001, 0, 2'b00, 0, 2'b00, 2'b00, {4'b0001, 6'b100000}));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_RACC));
    vecs.push_back(v(0, 4'b0000, 1, 2'b01, 0, 2'b00, 2'b00, O_SOLOB));
    vecs.push_back(v(1, 4'b0000, 0, 2'b00, 1, 2'b10, 2'b00, {4'b0000, 6'b100000}));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_NULLO));
    vecs.push_back(v(0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, O_RACC));

    @(posedge clk);
    #1;
    chk("reset_values", outs, O_FERMO);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // lone move expires after TIMEOUT cycles
    step(v(0, 4'h0, 1, 2'b10, 0, 2'b00, 2'b00, O_SOLOB), "to_cattura_a");
    for (int k = 0; k < 15; k++) idle(O_SOLOB, $sformatf("to_attesa%0d", k));
    idle({4'b0000, 6'b011100}, "to_scaduto");
    idle(O_RACC, "to_dopo");

    // opponent lands on the expiry cycle: pair wins, no timeout
    step(v(0, 4'h0, 1, 2'b10, 0, 2'b00, 2'b00, O_SOLOB), "tc_cattura_a");
    for (int k = 0; k < 15; k++) idle(O_SOLOB, $sformatf("tc_attesa%0d", k));
    step(v(0, 4'h0, 0, 2'b00, 1, 2'b01, 2'b00, {4'b1001, 6'b000000}), "tc_emetti");
    idle(O_NULLO, "tc_pausa0");
    idle(O_NULLO, "tc_pausa1");
    idle(O_RACC,  "tc_raccolta");

    // asynchronous reset with slot A full
    step(v(0, 4'h0, 1, 2'b11, 0, 2'b00, 2'b00, O_SOLOB), "rs_cattura_a");
    #3;
    rst_n = 1'b0;
    #1;
    chk("rs_async_raccolta", outs, O_FERMO);
    @(negedge clk);
    rst_n = 1'b1;
    idle(O_FERMO, "rs_fermo");
    avvio(4'b1001, "rs2");

    // asynchronous reset while a pair is on the outputs
    step(v(0, 4'h0, 1, 2'b01, 1, 2'b10, 2'b00, {4'b0110, 6'b000000}), "rs_emetti");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_emetti", outs, O_FERMO);
    @(negedge clk);
    rst_n = 1'b1;
    idle(O_FERMO, "rs_fermo2");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
